// File: rtl/serial_parity_rx.sv
// serial_parity_rx
// Receives one serial frame at a time: start(0), NDATA data bits LSB first,
// one even-parity bit, stop(1). The data word is deserialised, the parity is
// accumulated bit by bit, and the stop bit is checked. The word is then
// presented together with its status flags.
//
// Parameters
//   NDATA       data bits per frame, 1..16
// Ports
//   clk_2       clock, all logic on the rising edge
//   reset       synchronous active-high reset
//   in_valid    qualifies in_bit; only qualified edges advance the receiver
//   in_bit      serial line, idles high
//   data_out    last received data word (updated even on errored frames)
//   data_valid  one-cycle pulse after the stop bit has been sampled
//   parity_err  last frame failed even parity
//   frame_err   last frame had a low stop bit
//   busy        frame in progress (state is not IDLE)
module serial_parity_rx #(
  parameter int NDATA = 8
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic [NDATA-1:0] data_out,
  output logic             data_valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             busy
);

  localparam int CW = (NDATA > 1) ? $clog2(NDATA) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NDATA - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t           state_r;
  logic [NDATA-1:0] shreg_r;
  logic [CW-1:0]    count_r;
  logic             parity_r;
  logic             perr_r;

  // Shift a new bit in at the MSB end; after NDATA shifts the first
  // (least significant) bit received sits at bit 0.
  function automatic logic [NDATA-1:0] shift_in(input logic [NDATA-1:0] s,
                                                input logic b);
    logic [NDATA-1:0] r;
    r = s;
    for (int i = 0; i < NDATA - 1; i++) begin
      r[i] = s[i + 1];
    end
    r[NDATA-1] = b;
    return r;
  endfunction

  // Running even-parity accumulator: XOR of every bit seen so far.
  function automatic logic parity_step(input logic p, input logic b);
    return p ^ b;
  endfunction

  // Receiver FSM with registered data path and status outputs.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_r    <= IDLE;
      shreg_r    <= '0;
      count_r    <= '0;
      parity_r   <= 1'b0;
      perr_r     <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      // data_valid is a pulse: low unless the stop bit is taken this edge
      data_valid <= 1'b0;
      if (in_valid) begin
        case (state_r)
          IDLE: begin
            if (!in_bit) begin
              state_r  <= DATA;
              count_r  <= '0;
              parity_r <= 1'b0;
            end else begin
              state_r <= IDLE;
            end
          end
          DATA: begin
            shreg_r  <= shift_in(shreg_r, in_bit);
            parity_r <= parity_step(parity_r, in_bit);
            if (count_r == LAST_IDX) begin
              state_r <= PARITY;
              count_r <= '0;
            end else begin
              count_r <= count_r + CW'(1);
            end
          end
          PARITY: begin
            // Non-zero total parity over data plus parity bit is an error
            perr_r  <= parity_step(parity_r, in_bit);
            state_r <= STOP;
          end
          STOP: begin
            data_out   <= shreg_r;
            parity_err <= perr_r;
            frame_err  <= ~in_bit;
            data_valid <= 1'b1;
            state_r    <= IDLE;
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  assign busy = (state_r != IDLE);

endmodule

// File: tb/tb_serial_parity_rx.sv
// Self-checking bench for serial_parity_rx (NDATA = 8). Frames are driven
// one bit per qualified clock; the expected word and flags are pushed to a
// scoreboard queue as each frame is driven and compared when data_valid fires.
module tb_serial_parity_rx;

  logic       clk_2;
  logic       reset;
  logic       in_valid;
  logic       in_bit;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks  = 0;
  int   n_pass    = 0;
  int   n_pulses  = 0;
  int   n_pushed  = 0;

  serial_parity_rx #(.NDATA(8)) dut (
    .clk_2      (clk_2),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    n_checks++;
    if (obs === expv) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Present one value on the inputs for the next rising edge.
  task automatic drive(input logic v, input logic b);
    @(posedge clk_2);
    #1;
    in_valid = v;
    in_bit   = b;
  endtask

  task automatic gap(input int max_gap);
    int n;
    n = (max_gap > 0) ? int'($urandom_range(1, max_gap)) : 0;
    for (int g = 0; g < n; g++) drive(1'b0, 1'($urandom_range(0, 1)));
  endtask

  // Drive a full frame; the expected result is derived from the frame bits.
  task automatic send_frame(input logic [7:0] d, input logic p,
                            input logic stop, input int max_gap);
    exp_t e;
    e.d  = d;
    e.pe = (^d) ^ p;
    e.fe = ~stop;
    exp_q.push_back(e);
    n_pushed++;
    drive(1'b1, 1'b0);
    gap(max_gap);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, d[i]);
      if (i == 0) check("busy_in_frame", 32'(busy), 32'd1);
      gap(max_gap);
    end
    drive(1'b1, p);
    gap(max_gap);
    drive(1'b1, stop);
  endtask

  // Scoreboard: every data_valid cycle must match the oldest expectation.
  always @(negedge clk_2) begin
    if (data_valid === 1'b1) begin
      n_pulses++;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("data_out", 32'(data_out), 32'(e.d));
        check("parity_err", 32'(parity_err), 32'(e.pe));
        check("frame_err", 32'(frame_err), 32'(e.fe));
      end
    end
  end

  task automatic drain();
    int t;
    t = 0;
    drive(1'b1, 1'b1);
    while (exp_q.size() != 0 && t < 20) begin
      drive(1'b1, 1'b1);
      t++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_bit   = 1'b1;
    repeat (2) @(posedge clk_2);
    #1;
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_parity_err", 32'(parity_err), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (3) drive(1'b1, 1'b1);
    check("idle_busy", 32'(busy), 32'd0);

    // 1: clean frame
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    drain();
    // 2: wrong parity
    send_frame(8'h07, 1'b0, 1'b1, 0);
    drain();
    // 3: bad stop bit
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    drain();
    // 4: in_valid gaps between bits
    send_frame(8'h81, 1'b0, 1'b1, 3);
    drain();

    // 5: reset after the 4th data bit aborts the frame
    drive(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'(8'h99 >> i));
    @(posedge clk_2);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk_2);
    #1;
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_data_out", 32'(data_out), 32'd0);
    check("abort_valid", 32'(data_valid), 32'd0);
    send_frame(8'h55, 1'b0, 1'b1, 0);
    drain();

    // 6: back-to-back frames with zero gap
    send_frame(8'h01, 1'b1, 1'b1, 0);
    send_frame(8'hFE, 1'b1, 1'b1, 0);
    drain();
    repeat (3) drive(1'b1, 1'b1);
    check("b2b_busy", 32'(busy), 32'd0);
    check("b2b_hold_data", 32'(data_out), 32'hFE);
    check("pulse_count", 32'(n_pulses), 32'(n_pushed));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
